// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - iterative radix-2 restoring divide controller for DIV/DIVU in E
// Signed support is built only when DIV_SIGNED_EN is defined; otherwise every request is unsigned.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             startE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancel,
  output logic             stall_div,
  output logic             busy,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, hi_q, lo_q;
  logic [WIDTH-1:0] a_abs, b_abs, rem_fix, quo_fix;
  logic [WIDTH:0]   rem_sh, trial;

`ifdef DIV_SIGNED_EN
  logic a_neg, b_neg, q_neg_q, r_neg_q;
  assign a_neg   = signedE & srcaE[WIDTH-1];
  assign b_neg   = signedE & srcbE[WIDTH-1];
  assign a_abs   = a_neg ? -srcaE : srcaE;
  assign b_abs   = b_neg ? -srcbE : srcbE;
  assign quo_fix = q_neg_q ? -quo_q : quo_q;
  assign rem_fix = r_neg_q ? -rem_q : rem_q;
`else
  logic unused_signed;
  assign unused_signed = signedE;
  assign a_abs   = srcaE;
  assign b_abs   = srcbE;
  assign quo_fix = quo_q;
  assign rem_fix = rem_q;
`endif

  // Remainder stays below the divisor, so WIDTH+1 bits hold the shifted trial without loss.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  assign busy      = (state_q != IDLE);
  assign hilo_we   = (state_q == DONE) & ~cancel;
  assign stall_div = (((state_q == IDLE) & startE) | (state_q == BUSY)) & ~cancel;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef DIV_SIGNED_EN
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
`endif
    end else if (cancel) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (startE) begin
            rem_q   <= '0;
            quo_q   <= a_abs;
            dvs_q   <= b_abs;
            cnt_q   <= '0;
`ifdef DIV_SIGNED_EN
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
`endif
            state_q <= BUSY;
          end
        end
        BUSY: begin
          rem_q <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= DONE;
        end
        DONE: begin
          hi_q    <= rem_fix;
          lo_q    <= quo_fix;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed self-checking bench for div_ctrl
module tb_div_ctrl;
  logic        clk = 1'b0;
  logic        resetn, startE, signedE, cancel;
  logic [31:0] srcaE, srcbE;
  logic        stall_div, busy, hilo_we;
  logic [31:0] hi_o, lo_o;
  int checks = 0;
  int errors = 0;
  int we_count = 0;

  div_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .startE(startE), .signedE(signedE),
    .srcaE(srcaE), .srcbE(srcbE), .cancel(cancel),
    .stall_div(stall_div), .busy(busy), .hilo_we(hilo_we),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (hilo_we === 1'b1) we_count++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one divide in the current cycle and returns the cycle offset of hilo_we; ends one cycle after it.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s, output int n);
    startE = 1'b1; signedE = s; srcaE = a; srcbE = b;
    step();
    startE = 1'b0;
    #1;
    n = 1;
    while (hilo_we !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    step();
  endtask

  task automatic test_reset();
    resetn = 1'b0; startE = 1'b0; signedE = 1'b0; cancel = 1'b0; srcaE = '0; srcbE = '0;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (stall_div !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_div); end
    checks++; if (hilo_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", hilo_we); end
    checks++; if ({hi_o, lo_o} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {hi_o, lo_o}); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_divu_basic();
    int bad = 0;
    startE = 1'b1; signedE = 1'b0; srcaE = 32'd100; srcbE = 32'd7;
    #1;
    checks++; if (stall_div !== 1'b1) begin errors++; $display("FAIL divu_stall_issue: got %b expected 1", stall_div); end
    step();
    startE = 1'b0;
    #1;
    for (int i = 1; i <= 32; i++) begin
      if (stall_div !== 1'b1 || busy !== 1'b1 || hilo_we !== 1'b0) bad++;
      step();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL divu_busy_window: got %0d bad cycles expected 0", bad); end
    checks++; if (hilo_we !== 1'b1) begin errors++; $display("FAIL divu_we_t33: got %b expected 1", hilo_we); end
    checks++; if (stall_div !== 1'b0) begin errors++; $display("FAIL divu_stall_done: got %b expected 0", stall_div); end
    step();
    checks++; if (lo_o !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected %h", lo_o, 32'd14); end
    checks++; if (hi_o !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected %h", hi_o, 32'd2); end
    checks++; if (hilo_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL divu_after: got we=%b busy=%b expected 0 0", hilo_we, busy); end
  endtask

  task automatic test_signed();
    int n;
    logic [31:0] elo, ehi;
    do_div(32'hFFFFFFF9, 32'd2, 1'b1, n);
`ifdef DIV_SIGNED_EN
    elo = 32'hFFFFFFFD; ehi = 32'hFFFFFFFF;
`else
    elo = 32'h7FFFFFFC; ehi = 32'h00000001;
`endif
    checks++; if (n !== 33) begin errors++; $display("FAIL sdiv_latency: got %0d expected 33", n); end
    checks++; if ({hi_o, lo_o} !== {ehi, elo}) begin errors++; $display("FAIL sdiv_m7_2: got %h expected %h", {hi_o, lo_o}, {ehi, elo}); end
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, n);
`ifdef DIV_SIGNED_EN
    elo = 32'h80000000; ehi = 32'h0;
`else
    elo = 32'h0; ehi = 32'h80000000;
`endif
    checks++; if ({hi_o, lo_o} !== {ehi, elo}) begin errors++; $display("FAIL sdiv_overflow: got %h expected %h", {hi_o, lo_o}, {ehi, elo}); end
    do_div(32'hFFFFFFF9, 32'd0, 1'b1, n);
`ifdef DIV_SIGNED_EN
    elo = 32'h00000001; ehi = 32'hFFFFFFF9;
`else
    elo = 32'hFFFFFFFF; ehi = 32'hFFFFFFF9;
`endif
    checks++; if ({hi_o, lo_o} !== {ehi, elo}) begin errors++; $display("FAIL sdiv_by_zero: got %h expected %h", {hi_o, lo_o}, {ehi, elo}); end
  endtask

  task automatic test_divu_zero();
    int n;
    do_div(32'h12345678, 32'd0, 1'b0, n);
    checks++; if ({hi_o, lo_o} !== {32'h12345678, 32'hFFFFFFFF}) begin errors++; $display("FAIL divu_by_zero: got %h expected %h", {hi_o, lo_o}, {32'h12345678, 32'hFFFFFFFF}); end
  endtask

  task automatic test_cancel();
    int n, we0;
    we0 = we_count;
    startE = 1'b1; signedE = 1'b0; srcaE = 32'd5000; srcbE = 32'd3;
    step();
    startE = 1'b0;
    for (int i = 1; i < 10; i++) step();
    cancel = 1'b1;
    #1;
    checks++; if (stall_div !== 1'b0) begin errors++; $display("FAIL cancel_stall: got %b expected 0", stall_div); end
    step();
    cancel = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b expected 0", busy); end
    step();
    checks++; if (we_count !== we0) begin errors++; $display("FAIL cancel_no_we: got %0d expected %0d", we_count, we0); end
    checks++; if ({hi_o, lo_o} !== {32'h12345678, 32'hFFFFFFFF}) begin errors++; $display("FAIL cancel_hold: got %h expected %h", {hi_o, lo_o}, {32'h12345678, 32'hFFFFFFFF}); end
    do_div(32'd1000, 32'd33, 1'b0, n);
    checks++; if (n !== 33) begin errors++; $display("FAIL cancel_restart_lat: got %0d expected 33", n); end
    checks++; if ({hi_o, lo_o} !== {32'd10, 32'd30}) begin errors++; $display("FAIL cancel_restart_res: got %h expected %h", {hi_o, lo_o}, {32'd10, 32'd30}); end
  endtask

  task automatic test_reset_mid();
    int we0;
    startE = 1'b1; signedE = 1'b0; srcaE = 32'd77; srcbE = 32'd5;
    step();
    startE = 1'b0;
    we0 = we_count;
    for (int i = 1; i < 20; i++) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    #1;
    checks++; if ({hi_o, lo_o} !== 64'h0) begin errors++; $display("FAIL rstmid_hilo: got %h expected 0", {hi_o, lo_o}); end
    checks++; if ({busy, stall_div, hilo_we} !== 3'b000) begin errors++; $display("FAIL rstmid_ctrl: got %b expected 000", {busy, stall_div, hilo_we}); end
    for (int i = 0; i < 40; i++) step();
    checks++; if (we_count !== we0) begin errors++; $display("FAIL rstmid_no_we: got %0d expected %0d", we_count, we0); end
  endtask

  task automatic test_back_to_back();
    int we0;
    we0 = we_count;
    startE = 1'b1; signedE = 1'b0; srcaE = 32'd1000; srcbE = 32'd10;
    for (int i = 0; i < 33; i++) step();
    checks++; if (hilo_we !== 1'b1) begin errors++; $display("FAIL b2b_we_first: got %b expected 1", hilo_we); end
    step();
    srcaE = 32'h12345678; srcbE = 32'd0;
    #1;
    checks++; if ({busy, stall_div} !== 2'b01) begin errors++; $display("FAIL b2b_restart_idle: got %b expected 01", {busy, stall_div}); end
    checks++; if ({hi_o, lo_o} !== {32'd0, 32'd100}) begin errors++; $display("FAIL b2b_res_first: got %h expected %h", {hi_o, lo_o}, {32'd0, 32'd100}); end
    for (int i = 0; i < 33; i++) step();
    checks++; if (hilo_we !== 1'b1) begin errors++; $display("FAIL b2b_we_second: got %b expected 1", hilo_we); end
    step();
    startE = 1'b0;
    #1;
    checks++; if ({hi_o, lo_o} !== {32'h12345678, 32'hFFFFFFFF}) begin errors++; $display("FAIL b2b_res_second: got %h expected %h", {hi_o, lo_o}, {32'h12345678, 32'hFFFFFFFF}); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (we_count !== we0 + 2) begin errors++; $display("FAIL b2b_we_count: got %0d expected %0d", we_count, we0 + 2); end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_divu_zero();
    test_cancel();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
# div_ctrl

Iterative 32-bit divide controller for the five-stage MIPS pipeline, serving DIV/DIVU in the execute stage. It latches operands when a divide reaches E and runs a radix-2 restoring divider for 32 iterations. While the divide runs, it holds the front of the pipeline frozen through a stall request that the hazard unit ORs into stallF/stallD and that also holds E. On completion it issues a single HI/LO write pulse with remainder and quotient.

## Interface
Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  synchronous active-low reset
- startE  in  1  divide instruction valid in E stage
- signedE  in  1  1 = DIV (signed), 0 = DIVU
- srcaE  in  WIDTH  dividend (forwarded rs value)
- srcbE  in  WIDTH  divisor (forwarded rt value)
- cancel  in  1  abort from exception/branch flush of E
- stall_div  out  1  freeze F, D, E while divide in progress
- busy  out  1  state != IDLE
- hilo_we  out  1  one-cycle HI/LO write strobe
- hi_o  out  WIDTH  remainder
- lo_o  out  WIDTH  quotient

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, with startE=1 and cancel=0:
  - latch |srcaE| and |srcbE|; absolute values apply only when signedE=1.
  - latch sign flags: q_neg = sign(a)^sign(b); r_neg = sign(a).
  - clear rem, load quotient register with dividend, clear cnt; go to BUSY.
- BUSY, each cycle:
  - form {rem,quo} shifted left 1 into trial = rem_shifted − divisor (WIDTH+1 bits).
  - if trial is non-negative: rem = trial, quo LSB = 1; else rem = rem_shifted, quo LSB = 0.
  - cnt++; on the iteration where cnt==WIDTH−1, go to DONE.
- DONE:
  - lo_o = q_neg ? −quo : quo; hi_o = r_neg ? −rem : rem (two's complement, WIDTH bits, wrap).
  - hilo_we=1; go to IDLE.
  - startE is ignored in DONE; the finishing instruction is still present in E that cycle.
- stall_div = ((IDLE & startE) | BUSY) & ~cancel. It is combinational so that the issuing cycle already holds E.
- cancel has priority in every state:
  - next state is IDLE; no hilo_we; hi_o/lo_o unchanged.
  - In DONE, cancel suppresses hilo_we and the result update.
- Divide by zero is not trapped:
  - unsigned result: lo=all ones, hi=dividend.
  - signed result: hi=srcaE; lo=all ones when srcaE≥0, 1 when srcaE<0. This is the natural sign-fix of the unsigned result.
- Overflow case 0x80000000 / −1 (signed): lo=0x80000000, hi=0.
- hi_o/lo_o are registers. They update only in DONE and hold between divides.

## Timing
- Reset (resetn=0 at posedge): state=IDLE, cnt=0, hi_o=0, lo_o=0, hilo_we=0, busy=0, internal operands 0. stall_div=0 while startE=0.
- Reset mid-divide aborts it with no write.
- Start accepted at edge T (startE high in cycle T).
- BUSY occupies cycles T+1..T+WIDTH; DONE is cycle T+WIDTH+1.
- hilo_we is high for exactly cycle T+WIDTH+1, with hi_o/lo_o valid from the following edge.
- stall_div is high for cycles T..T+WIDTH (WIDTH+1 cycles) and low in DONE, so the pipeline advances as the write commits.
- Back-to-back divides: the next instruction reaches E at T+WIDTH+2 and starts from IDLE. Minimum spacing is WIDTH+2 cycles.
- cancel in cycle C: state is IDLE at C+1 and stall_div is 0 in cycle C.

## Configuration
- DIV_SIGNED_EN defined: signedE is honoured (abs/negate logic and sign flags are present).
- DIV_SIGNED_EN undefined: signedE is ignored and every request is unsigned; the negation logic is not synthesized.

## Test plan
- DIVU 100/7, start at T: stall_div high T..T+32, hilo_we only at T+33, then lo=14, hi=2.
- DIV 0xFFFFFFF9(−7)/2 (DIV_SIGNED_EN): lo=0xFFFFFFFD, hi=0xFFFFFFFF. Without the macro, the same request yields lo=0x7FFFFFFC, hi=1.
- DIVU 0x12345678/0: lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- cancel asserted at T+10: stall_div=0 that cycle, busy=0 at T+11, no hilo_we, hi/lo unchanged. A new start at T+12 completes normally at T+45.
- resetn low at T+20 of a divide: all outputs 0 next cycle, no hilo_we ever pulses for that divide.
- startE held high through DONE: no restart. Two divides issued with spacing WIDTH+2 each produce exactly one hilo_we with correct results.
